// File: rtl/modulo_transfer_rolhas_param_pkg.sv
// modulo_transfer_rolhas_param_pkg: FSM state encoding and timeout counter width
package modulo_transfer_rolhas_param_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2,
    ERRO     = 2'd3
  } state_t;
  localparam int TO_W = 8;
endpackage

// File: rtl/modulo_transfer_rolhas_param_timeout.sv
// contador_timeout: REQ-phase cycle counter with clear, enable and terminal flag at TIMEOUT
module contador_timeout
  import modulo_transfer_rolhas_param_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);
  logic [TO_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_term = r_cnt == TO_W'(TIMEOUT);
endmodule

// File: rtl/modulo_transfer_rolhas_param.sv
// modulo_transfer_rolhas_param: reservoir/dispenser cork counters with req/ack batch transfer
module modulo_transfer_rolhas_param
  import modulo_transfer_rolhas_param_pkg::*;
#(
  parameter int W            = 7,
  parameter int DW           = 5,
  parameter int TRANSFER_MIN = 20,
  parameter int BATCH        = 15,
  parameter int DISP_MAX     = 20,
  parameter int ADD_QTY      = 10,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          add_rolhas,
  input  logic          consume_rolha,
  input  logic          transfer_ack,
  input  logic          clr_erro,
  output logic [W-1:0]  reg_r,
  output logic [DW-1:0] disp_r,
  output logic          transfer_rolhas,
  output logic          alarme_estoque,
  output logic          falta_rolha,
  output logic          erro_timeout
);
  localparam logic [W:0]    C_RES_MAX = {1'b0, {W{1'b1}}};
  localparam logic [W:0]    C_ADD     = (W+1)'(ADD_QTY);
  localparam logic [W:0]    C_BATCH_R = (W+1)'(BATCH);
  localparam logic [W-1:0]  C_TMIN    = W'(TRANSFER_MIN);
  localparam logic [DW:0]   C_BATCH_D = (DW+1)'(BATCH);
  localparam logic [DW-1:0] C_HEAD    = DW'(DISP_MAX - BATCH);
  state_t        r_state, w_next;
  logic [W-1:0]  r_reg;
  logic [DW-1:0] r_disp;
  logic          w_can_tx, w_xfer, w_cnt_clr, w_cnt_en, w_term, w_dec;
  logic [W:0]    w_reg_sum;
  logic [DW:0]   w_disp_sum;
  contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_term  (w_term)
  );
  assign w_can_tx = (r_reg >= C_TMIN) && (r_disp <= C_HEAD);
  always_comb begin
    w_next    = r_state;
    w_xfer    = 1'b0;
    w_cnt_clr = 1'b1;
    w_cnt_en  = 1'b0;
    unique case (r_state)
      IDLE:     w_next = (w_can_tx && !transfer_ack) ? REQ : IDLE;
      REQ: begin
        w_xfer    = transfer_ack;
        w_cnt_clr = transfer_ack || w_term;
        w_cnt_en  = 1'b1;
        w_next    = transfer_ack ? WAIT_LOW : (w_term ? ERRO : REQ);
      end
      WAIT_LOW: w_next = transfer_ack ? WAIT_LOW : IDLE;
      ERRO:     w_next = clr_erro ? IDLE : ERRO;
    endcase
  end
  // an empty dispenser swallows a consume pulse unless a batch lands on the same edge
  assign w_dec      = consume_rolha && (w_xfer || r_disp != '0);
  assign w_reg_sum  = {1'b0, r_reg} + (add_rolhas ? C_ADD : '0) - (w_xfer ? C_BATCH_R : '0);
  assign w_disp_sum = {1'b0, r_disp} + (w_xfer ? C_BATCH_D : '0) - (w_dec ? (DW+1)'(1) : '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_reg   <= '0;
      r_disp  <= '0;
    end else begin
      r_state <= w_next;
      r_reg   <= (w_reg_sum > C_RES_MAX) ? C_RES_MAX[W-1:0] : w_reg_sum[W-1:0];
      r_disp  <= w_disp_sum[DW-1:0];
    end
  end
  assign reg_r           = r_reg;
  assign disp_r          = r_disp;
  assign transfer_rolhas = r_state == REQ;
  assign erro_timeout    = r_state == ERRO;
  assign alarme_estoque  = r_reg < C_TMIN;
  assign falta_rolha     = r_disp == '0;
endmodule

// File: tb/tb_modulo_transfer_rolhas_param.sv
// tb_modulo_transfer_rolhas_param: directed scenarios plus random traffic against a behavioural model
module tb_modulo_transfer_rolhas_param;
  localparam int RES_MAX = 127;
  localparam int TMIN = 20, BATCH = 15, DMAX = 20, ADDQ = 10, TOUT = 255;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_ERR = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic add_rolhas = 1'b0, consume_rolha = 1'b0, transfer_ack = 1'b0, clr_erro = 1'b0;
  logic [6:0] reg_r;
  logic [4:0] disp_r;
  logic transfer_rolhas, alarme_estoque, falta_rolha, erro_timeout;
  int checks = 0, failures = 0;
  bit chk_on = 1'b0;
  int m_reg = 0, m_disp = 0, m_ph = P_IDLE, m_wait = 0;
  int nr, nd, n;
  bit xfer;

  modulo_transfer_rolhas_param dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .add_rolhas      (add_rolhas),
    .consume_rolha   (consume_rolha),
    .transfer_ack    (transfer_ack),
    .clr_erro        (clr_erro),
    .reg_r           (reg_r),
    .disp_r          (disp_r),
    .transfer_rolhas (transfer_rolhas),
    .alarme_estoque  (alarme_estoque),
    .falta_rolha     (falta_rolha),
    .erro_timeout    (erro_timeout)
  );

  always #5 clk = ~clk;

  // Reference: stock counts as plain integers, handshake as a phase plus elapsed REQ cycles
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg = 0; m_disp = 0; m_ph = P_IDLE; m_wait = 0;
    end else begin
      xfer = (m_ph == P_REQ) && transfer_ack;
      nr = m_reg + (add_rolhas ? ADDQ : 0) - (xfer ? BATCH : 0);
      if (nr > RES_MAX) nr = RES_MAX;
      nd = m_disp + (xfer ? BATCH : 0);
      if (consume_rolha && nd > 0) nd = nd - 1;
      case (m_ph)
        P_IDLE: if (m_reg >= TMIN && m_disp <= DMAX - BATCH && !transfer_ack) begin
          m_ph = P_REQ; m_wait = 0;
        end
        P_REQ: begin
          if (transfer_ack) m_ph = P_WAIT;
          else if (m_wait == TOUT) m_ph = P_ERR;
          else m_wait = m_wait + 1;
        end
        P_WAIT: if (!transfer_ack) m_ph = P_IDLE;
        default: if (clr_erro) m_ph = P_IDLE;
      endcase
      m_reg = nr; m_disp = nd;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("model_reg_r", int'(reg_r), m_reg);
    chk("model_disp_r", int'(disp_r), m_disp);
    chk("model_req", int'(transfer_rolhas), int'(m_ph == P_REQ));
    chk("model_erro", int'(erro_timeout), int'(m_ph == P_ERR));
    chk("model_alarme", int'(alarme_estoque), int'(m_reg < TMIN));
    chk("model_falta", int'(falta_rolha), int'(m_disp == 0));
  end

  task automatic cyc(input bit a, input bit c, input bit k, input bit e);
    add_rolhas = a; consume_rolha = c; transfer_ack = k; clr_erro = e;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    cyc(0, 0, 0, 0);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_reg", int'(reg_r), 0);
    chk("rst_req", int'(transfer_rolhas), 0);
    chk("rst_falta", int'(falta_rolha), 1);
    chk("rst_alarme", int'(alarme_estoque), 1);
    // async reset in the middle of a request
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("pre_rst_req", int'(transfer_rolhas), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_reg", int'(reg_r), 0);
    chk("async_rst_req", int'(transfer_rolhas), 0);
    chk("async_rst_erro", int'(erro_timeout), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", int'(transfer_rolhas), 0);
    // normal transfer
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("norm_reg20", int'(reg_r), 20);
    chk("norm_req_not_yet", int'(transfer_rolhas), 0);
    cyc(0, 0, 0, 0);
    chk("norm_req", int'(transfer_rolhas), 1);
    cyc(0, 0, 1, 0);
    chk("norm_reg5", int'(reg_r), 5);
    chk("norm_disp15", int'(disp_r), 15);
    chk("norm_req_low", int'(transfer_rolhas), 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("norm_alarme", int'(alarme_estoque), 1);
    chk("norm_no_rereq", int'(transfer_rolhas), 0);
    // headroom
    repeat (9) cyc(0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("head_reg35", int'(reg_r), 35);
    chk("head_disp6", int'(disp_r), 6);
    chk("head_no_req", int'(transfer_rolhas), 0);
    cyc(0, 1, 0, 0);
    chk("head_disp5", int'(disp_r), 5);
    cyc(0, 0, 0, 0);
    chk("head_req", int'(transfer_rolhas), 1);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    chk("head_after_reg", int'(reg_r), 20);
    chk("head_after_disp", int'(disp_r), 20);
    // simultaneous ack + add + consume
    repeat (17) cyc(0, 1, 0, 0);
    chk("sim_in_req", int'(transfer_rolhas), 1);
    chk("sim_disp3", int'(disp_r), 3);
    cyc(1, 1, 1, 0);
    chk("sim_reg15", int'(reg_r), 15);
    chk("sim_disp17", int'(disp_r), 17);
    cyc(0, 0, 0, 0);
    // timeout
    cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("to_req", int'(transfer_rolhas), 1);
    n = 0;
    while (!erro_timeout && n < 400) begin cyc(0, 0, 0, 0); n++; end
    chk("to_erro", int'(erro_timeout), 1);
    chk("to_reg25", int'(reg_r), 25);
    chk("to_disp5", int'(disp_r), 5);
    repeat (3) cyc(0, 0, 0, 0);
    chk("to_no_req_in_erro", int'(transfer_rolhas), 0);
    cyc(0, 0, 0, 1);
    chk("to_cleared", int'(erro_timeout), 0);
    cyc(0, 0, 0, 0);
    chk("to_rereq", int'(transfer_rolhas), 1);
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    // bounds
    do_reset();
    repeat (13) cyc(1, 0, 0, 0);
    chk("sat_127", int'(reg_r), 127);
    cyc(1, 0, 0, 0);
    chk("sat_hold", int'(reg_r), 127);
    cyc(0, 1, 0, 0);
    chk("consume_empty", int'(disp_r), 0);
    chk("falta_empty", int'(falta_rolha), 1);
    // random traffic
    do_reset();
    repeat (3000)
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
